vec_writeback: RTL and testbench
================================

// Module: vec_writeback
// PURPOSE
//  Writeback stage behind the vector ALU. Captures the 1024-bit ALU result
//  (A3 = low 512 bits, A4 = high 512 bits) and streams it as WORD_W-bit beats
//  into the vector register file write port using a valid/ready handshake.
//  Narrow ops write A3 to rd_lo only. Wide ops (full multiply product) write
//  A3 to rd_lo, then A4 to rd_hi.
// PARAMETERS
//  VLEN    512  vector register width in bits (A3/A4 width)
//  WORD_W  32   write-port beat width; VLEN % WORD_W == 0
//  REG_W   3    register index width (8 vector registers)
//  NW      VLEN/WORD_W (derived, 16); IDX_W = clog2(NW) (derived, 4)
// PORTS
//  clk       in   1       clock, all logic on posedge
//  reset     in   1       synchronous, active-high
//  start     in   1       request: capture A3/A4/rd_lo/rd_hi/wide this cycle
//  wide      in   1       1 = write A3 and A4; 0 = write A3 only
//  rd_lo     in   REG_W   destination register for A3
//  rd_hi     in   REG_W   destination register for A4
//  A3        in   VLEN    ALU result, low half
//  A4        in   VLEN    ALU result, high half
//  busy      out  1       high from the cycle after an accepted start through DONE
//  done      out  1       one-cycle pulse after the last beat is accepted
//  wr_en     out  1       beat valid
//  wr_ready  in   1       register file accepts the beat when wr_en & wr_ready
//  wr_reg    out  REG_W   beat destination register
//  wr_word   out  IDX_W   beat word index within the register
//  wr_data   out  WORD_W  beat data
//  overrun   out  1       present only with VWB_OVERRUN_EN
// BEHAVIOUR
//  - Reset: state IDLE. busy, done, wr_en, wr_reg, wr_word, wr_data all 0.
//    Shadow registers cleared. Reset wins over every other input in the same cycle.
//  - FSM states:
//    - IDLE: start -> capture operands into shadow regs; go to LO, word 0.
//    - LO: wr_en=1, wr_reg=rd_lo, wr_data=A3[WORD_W*w +: WORD_W].
//    - HI: same as LO using rd_hi and A4.
//    - DONE: done=1, busy=1, wr_en=0 for one cycle; then IDLE.
//  - Beat rules:
//    - A beat is accepted when wr_en & wr_ready.
//    - On acceptance: w increments. At w == NW-1, LO goes to HI (wide) or DONE
//      (narrow); HI goes to DONE. w wraps to 0.
//    - While wr_en=1 and wr_ready=0: wr_reg, wr_word and wr_data are held stable.
//  - Outputs are registered. With wr_ready held high:
//    - narrow: beats in cycles 1..NW after start, done at NW+1 (17).
//    - wide: beats in cycles 1..2*NW, done at 2*NW+1 (33).
//  - start is accepted only in IDLE. In LO/HI/DONE it is ignored; the shadow
//    regs are not modified and the transfer in progress is unaffected.
//  - A3/A4 are sampled only in the start cycle. Later changes have no effect.
//  - rd_lo == rd_hi is legal: HI overwrites LO, in beat order.
//  - Reset mid-transfer: next cycle IDLE, wr_en=0. Beats already accepted stay
//    written; the remaining beats are dropped; done is never pulsed.
//  - Outside LO/HI, wr_reg, wr_word and wr_data are driven to 0.
// CONFIGURATION
//  - VWB_OVERRUN_EN defined: adds output overrun. It is set (sticky) the cycle
//    after a start arrives while busy=1, and cleared only by reset.
//  - VWB_OVERRUN_EN undefined: no overrun port; starts while busy are silently ignored.
//  - All other behaviour is identical in both builds.
// TESTING
//  1. reset=1 for 2 cycles with start=1 -> busy=0, done=0, wr_en=0, wr_data=0; no beats.
//  2. Narrow op: wide=0, rd_lo=3, A3 word i = i+1, wr_ready=1 ->
//     beats cycles 1..16, reg 3, words 0..15, data 1..16; done pulse in cycle 17 only.
//  3. Wide op: rd_lo=2, rd_hi=5, A4 word i = 0x100+i ->
//     32 beats (reg 2 words 0..15, then reg 5 data 0x100..0x10F); done in cycle 33.
//  4. Narrow op with wr_ready=0 in cycles 2..4 -> word 1 held stable for 4 cycles;
//     16 beats total; done in cycle 20.
//  5. reset in cycle 6 of a wide op -> wr_en=0 from cycle 7, no done;
//     new start replays from reg rd_lo, word 0, using the new operands.
//  6. start again in cycle 4 with different A3 -> ignored, original data completes.
//     With VWB_OVERRUN_EN: overrun=1 from cycle 5 until reset.

Source files
------------

// File: rtl/vec_writeback.sv
// Vector ALU writeback: captures A3/A4 and streams them as WORD_W beats into the VRF write port.
// Optional build macro VWB_OVERRUN_EN adds a sticky overrun flag for starts that arrive while busy.
//
// state | meaning
// IDLE  | waiting for start
// LO    | streaming A3 words to rd_lo
// HI    | streaming A4 words to rd_hi (wide ops only)
// DONE  | one-cycle completion pulse
module vec_writeback #(
  parameter  int VLEN   = 512,
  parameter  int WORD_W = 32,
  parameter  int REG_W  = 3,
  localparam int NW     = VLEN / WORD_W,
  localparam int IDX_W  = $clog2(NW)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wide,
  input  logic [REG_W-1:0]  rd_lo,
  input  logic [REG_W-1:0]  rd_hi,
  input  logic [VLEN-1:0]   A3,
  input  logic [VLEN-1:0]   A4,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [REG_W-1:0]  wr_reg,
  output logic [IDX_W-1:0]  wr_word,
  output logic [WORD_W-1:0] wr_data
`ifdef VWB_OVERRUN_EN
  ,
  output logic              overrun
`endif
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_W = IDX_W'(NW - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   w_q, w_d;
  logic [VLEN-1:0]    a3_q, a3_d, a4_q, a4_d;
  logic [REG_W-1:0]   rd_lo_q, rd_lo_d, rd_hi_q, rd_hi_d;
  logic               wide_q, wide_d;
  logic               busy_q, busy_d, done_q, done_d, wr_en_q, wr_en_d;
  logic [REG_W-1:0]   wr_reg_q, wr_reg_d;
  logic [IDX_W-1:0]   wr_word_q, wr_word_d;
  logic [WORD_W-1:0]  wr_data_q, wr_data_d;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    a3_d    = a3_q;
    a4_d    = a4_q;
    rd_lo_d = rd_lo_q;
    rd_hi_d = rd_hi_q;
    wide_d  = wide_q;
    case (state_q)
      IDLE: if (start) begin
        a3_d    = A3;
        a4_d    = A4;
        rd_lo_d = rd_lo;
        rd_hi_d = rd_hi;
        wide_d  = wide;
        w_d     = '0;
        state_d = LO;
      end
      LO, HI: if (wr_ready) begin
        if (w_q == LAST_W) begin
          w_d     = '0;
          state_d = (state_q == LO && wide_q) ? HI : DONE;
        end else begin
          w_d = w_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are precomputed from the next state so every port comes straight from a flop.
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    wr_en_d   = (state_d == LO) || (state_d == HI);
    wr_reg_d  = '0;
    wr_word_d = '0;
    wr_data_d = '0;
    if (state_d == LO) begin
      wr_reg_d  = rd_lo_d;
      wr_word_d = w_d;
      wr_data_d = a3_d[int'(w_d)*WORD_W +: WORD_W];
    end else if (state_d == HI) begin
      wr_reg_d  = rd_hi_d;
      wr_word_d = w_d;
      wr_data_d = a4_d[int'(w_d)*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      w_q       <= '0;
      a3_q      <= '0;
      a4_q      <= '0;
      rd_lo_q   <= '0;
      rd_hi_q   <= '0;
      wide_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_word_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      a3_q      <= a3_d;
      a4_q      <= a4_d;
      rd_lo_q   <= rd_lo_d;
      rd_hi_q   <= rd_hi_d;
      wide_q    <= wide_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_word_q <= wr_word_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_word = wr_word_q;
  assign wr_data = wr_data_q;

`ifdef VWB_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q | (start & busy_q);
  end

  always_ff @(posedge clk) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_vec_writeback.sv
// Scoreboard bench for vec_writeback: stimulus pushes expected beats/done cycles, a negedge monitor pops and compares.
module tb_vec_writeback;
  localparam int VLEN = 512, WORD_W = 32, REG_W = 3, NW = 16, IDX_W = 4;

  logic clk = 1'b0;
  logic reset, start, wide, wr_ready;
  logic [REG_W-1:0] rd_lo, rd_hi;
  logic [VLEN-1:0] a3, a4;
  logic busy, done, wr_en;
  logic [REG_W-1:0] wr_reg;
  logic [IDX_W-1:0] wr_word;
  logic [WORD_W-1:0] wr_data;
`ifdef VWB_OVERRUN_EN
  logic overrun;
`endif

  vec_writeback #(.VLEN(VLEN), .WORD_W(WORD_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .start(start), .wide(wide),
    .rd_lo(rd_lo), .rd_hi(rd_hi), .A3(a3), .A4(a4),
    .busy(busy), .done(done), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_reg(wr_reg), .wr_word(wr_word), .wr_data(wr_data)
`ifdef VWB_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [REG_W-1:0]  rg;
    logic [IDX_W-1:0]  word;
    logic [WORD_W-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    done_q[$];
  beat_t head;
  int    errors = 0, checks = 0;
  int    cyc = 0, start_cyc = 0, exp_done;
  logic  mon_en = 1'b0;
  logic  exp_ovr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_en) begin
        if (exp_q.size() == 0) fail("spurious_beat", "wr_en high with no beat expected");
        else begin
          head = exp_q[0];
          if (!wr_ready) check("hold_beat", {wr_reg, wr_word, wr_data}, {head.rg, head.word, head.data});
          else begin
            check("beat_reg", 64'(wr_reg), 64'(head.rg));
            check("beat_word", 64'(wr_word), 64'(head.word));
            check("beat_data", 64'(wr_data), 64'(head.data));
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("idle_outputs", {wr_reg, wr_word, wr_data}, 64'd0);
      end
      if (done) begin
        if (done_q.size() == 0) fail("spurious_done", "done pulsed with none expected");
        else begin
          exp_done = done_q.pop_front();
          check("done_cycle", 64'(cyc - start_cyc), 64'(exp_done));
          check("done_drained", 64'(exp_q.size()), 64'd0);
          check("done_busy", 64'(busy), 64'd1);
        end
      end
`ifdef VWB_OVERRUN_EN
      check("overrun", 64'(overrun), 64'(exp_ovr));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] v;
    for (int i = 0; i < NW; i++) v[i*WORD_W +: WORD_W] = $urandom;
    return v;
  endfunction

  // mode 0: ready always high; 1: ready low in cycles 2..4; 2: random ready.
  // restart_at > 0 issues a second (ignored) start in that relative cycle.
  task automatic run_op(input logic w, input logic [REG_W-1:0] lo, input logic [REG_W-1:0] hi,
                        input logic [VLEN-1:0] x3, input logic [VLEN-1:0] x4,
                        input int mode, input int restart_at);
    logic rdy [0:255];
    int nb, cnt, ed;
    nb = w ? 2*NW : NW;
    for (int k = 0; k < 256; k++) begin
      case (mode)
        1:       rdy[k] = !(k >= 2 && k <= 4);
        2:       rdy[k] = (k >= 150) ? 1'b1 : ($urandom_range(0, 3) != 0);
        default: rdy[k] = 1'b1;
      endcase
    end
    cnt = 0;
    ed = 0;
    for (int k = 1; k < 256; k++) begin
      if (rdy[k]) cnt++;
      if (cnt == nb && ed == 0) ed = k + 1;
    end
    for (int i = 0; i < NW; i++) exp_q.push_back('{lo, IDX_W'(i), x3[i*WORD_W +: WORD_W]});
    if (w) for (int i = 0; i < NW; i++) exp_q.push_back('{hi, IDX_W'(i), x4[i*WORD_W +: WORD_W]});
    done_q.push_back(ed);

    start = 1'b1; wide = w; rd_lo = lo; rd_hi = hi; a3 = x3; a4 = x4; wr_ready = rdy[0];
    start_cyc = cyc;
    tick();
    check("busy_after_start", 64'(busy), 64'd1);
    for (int k = 1; k <= ed; k++) begin
      if (k == restart_at) begin
        start = 1'b1; wide = ~w; rd_lo = ~lo; rd_hi = ~hi;
      end else begin
        start = 1'b0;
      end
      a3 = rand_vec(); a4 = rand_vec();
      wr_ready = rdy[k];
      tick();
      if (k == restart_at) exp_ovr = 1'b1;
    end
    start = 1'b0;
    wr_ready = 1'b1;
    check("op_done_seen", 64'(done_q.size()), 64'd0);
    check("op_beats_left", 64'(exp_q.size()), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic run_reset_mid(input logic [REG_W-1:0] lo, input logic [REG_W-1:0] hi, input int reset_at);
    logic [VLEN-1:0] x3, x4;
    x3 = rand_vec(); x4 = rand_vec();
    for (int i = 0; i < NW; i++) exp_q.push_back('{lo, IDX_W'(i), x3[i*WORD_W +: WORD_W]});
    for (int i = 0; i < NW; i++) exp_q.push_back('{hi, IDX_W'(i), x4[i*WORD_W +: WORD_W]});
    start = 1'b1; wide = 1'b1; rd_lo = lo; rd_hi = hi; a3 = x3; a4 = x4; wr_ready = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    for (int k = 1; k <= reset_at; k++) begin
      reset = (k == reset_at);
      tick();
    end
    reset = 1'b0;
    check("rst_beats_taken", 64'(2*NW - exp_q.size()), 64'(reset_at));
    exp_q.delete();
    exp_ovr = 1'b0;
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 5; k++) tick();
  endtask

  initial begin
    logic [VLEN-1:0] v3, v4;
    reset = 1'b1; start = 1'b1; wide = 1'b1; wr_ready = 1'b1;
    rd_lo = 3'd1; rd_hi = 3'd2; a3 = rand_vec(); a4 = rand_vec();
    tick();
    mon_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_wr_en", 64'(wr_en), 64'd0);
      check("reset_wr_data", 64'(wr_data), 64'd0);
      tick();
    end
    reset = 1'b0; start = 1'b0;
    tick();

    for (int i = 0; i < NW; i++) v3[i*WORD_W +: WORD_W] = WORD_W'(i + 1);
    run_op(1'b0, 3'd3, 3'd0, v3, rand_vec(), 0, 0);

    for (int i = 0; i < NW; i++) v4[i*WORD_W +: WORD_W] = WORD_W'(32'h100 + i);
    run_op(1'b1, 3'd2, 3'd5, rand_vec(), v4, 0, 0);

    run_op(1'b0, 3'd4, 3'd0, rand_vec(), rand_vec(), 1, 0);

    run_reset_mid(3'd6, 3'd1, 6);
    run_op(1'b1, 3'd6, 3'd1, rand_vec(), rand_vec(), 0, 0);

    run_op(1'b0, 3'd7, 3'd0, rand_vec(), rand_vec(), 0, 4);
    run_op(1'b1, 3'd2, 3'd2, rand_vec(), rand_vec(), 0, 33);

    for (int n = 0; n < 6; n++)
      run_op(1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom), rand_vec(), rand_vec(), 2,
             ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 16)) : 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_ovr = 1'b0;
    tick();
    check("final_done_q", 64'(done_q.size()), 64'd0);
    check("final_exp_q", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
